ram_stream_reader: RTL

Single-clock read-side DMA engine for the two-port RAM. It accepts a command of start address and length, and issues sequential reads on the RAM read port. Read data is returned on a valid/ready output stream with backpressure, using an internal 3-entry buffer. It sits between the RAM read port (RAM read clock tied to `clk_i`) and any streaming consumer.

---
 rtl/ram_stream_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// Read-side DMA engine: turns an (addr, len) command into sequential RAM reads
// and returns the words on a valid/ready stream through a 3-entry buffer.
module ram_stream_reader #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [$clog2(Depth)-1:0]   cmd_addr_i,
  input  logic [$clog2(Depth):0]     cmd_len_i,
  output logic                       ram_re_o,
  output logic [$clog2(Depth)-1:0]   ram_raddr_o,
  input  logic [Width-1:0]           ram_rdata_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [Width-1:0]           m_data_o,
  output logic                       m_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Lw = Aw + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [Aw-1:0]     r_addr;
  logic [Lw-1:0]     r_rem;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;
  logic [Width-1:0]  r_buf_data [3];
  logic              r_buf_last [3];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [1:0]        r_count;

  logic              w_issue;
  logic              w_accept;
  logic              w_drain_done;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_occ;

  // Advance a buffer pointer modulo 3
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : 2'(p + 2'd1);
  endfunction

  // Buffered plus in-flight words; gates read-ahead to the buffer size
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_push = r_inflight;
  assign w_pop  = m_valid_o && m_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and issue decisions; depends on registered state only (plus cmd inputs)
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = cmd_valid_i;
        if (cmd_valid_i) begin
          w_state_nxt = (cmd_len_i == '0) ? ST_DRAIN : ST_READ;
        end
      end
      ST_READ: begin
        if (r_rem == '0) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_occ < 3'd3) begin
          w_issue = 1'b1;
          if (r_rem == Lw'(1)) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_count == 2'd0 && !r_inflight) begin
          w_drain_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address/length bookkeeping, in-flight tracking and completion pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rem == Lw'(1));
      r_done          <= w_drain_done;
      if (w_accept && cmd_len_i != '0) begin
        r_addr <= cmd_addr_i;
        r_rem  <= cmd_len_i;
      end else if (w_issue) begin
        r_addr <= (r_addr == Aw'(Depth - 1)) ? '0 : Aw'(r_addr + Aw'(1));
        r_rem  <= Lw'(r_rem - Lw'(1));
      end
    end
  end

  // 3-entry output FIFO; RAM data is captured only when a read was issued last cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wptr] <= ram_rdata_i;
        r_buf_last[r_wptr] <= r_inflight_last;
        r_wptr             <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= 2'(r_count + 2'd1);
        2'b01:   r_count <= 2'(r_count - 2'd1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign ram_re_o    = w_issue;
  assign ram_raddr_o = r_addr;
  assign m_valid_o   = (r_count != 2'd0);
  assign m_data_o    = r_buf_data[r_rptr];
  assign m_last_o    = r_buf_last[r_rptr];

endmodule
